fp_compare_pipe: RTL and testbench

Parametrised, handshaked, two-stage pipelined comparator for FloPoCo-format floats. It is the successor to the subtractor-based ≥ test used in the ray/AABB slab datapath. It compares directly on exception/sign/exponent/fraction, so no FPSub is instantiated. It supports eight ops: six predicates plus IEEE-style min/max select, and it flags unordered (NaN) results. It feeds the slab-interval (tmin/tmax) update and hit-decision logic, and a tag travels with each operand pair.

---
 rtl/fp_flopoco_pkg.sv | 38 +++
 rtl/fp_classify.sv | 36 +++
 rtl/fp_compare_pipe.sv | 167 ++++++++++++++++
 tb/tb_fp_compare_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_flopoco_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fp_flopoco_pkg : shared FloPoCo float encodings, op codes and field helpers
// Rev 1.0
// -----------------------------------------------------------------------------
package fp_flopoco_pkg;

  localparam logic [1:0] EXC_ZERO = 2'b00;
  localparam logic [1:0] EXC_NORM = 2'b01;
  localparam logic [1:0] EXC_INF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  typedef enum logic [2:0] {
    OP_GE  = 3'b000,
    OP_GT  = 3'b001,
    OP_LE  = 3'b010,
    OP_LT  = 3'b011,
    OP_EQ  = 3'b100,
    OP_NE  = 3'b101,
    OP_MIN = 3'b110,
    OP_MAX = 3'b111
  } op_e;

  // Field positions for an operand laid out as {exc, sign, exp, frac}
  function automatic int fp_width(input int we, input int wf);
    return we + wf + 3;
  endfunction

  function automatic int exc_lsb(input int we, input int wf);
    return we + wf + 1;
  endfunction

  function automatic int sign_bit(input int we, input int wf);
    return we + wf;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fp_classify : splits one FloPoCo operand into an unsigned magnitude key and flags
// Rev 1.0
// -----------------------------------------------------------------------------
module fp_classify
  import fp_flopoco_pkg::*;
#(
  parameter int WE = 11,
  parameter int WF = 10
) (
  input  logic [WE+WF+2:0] x_i,
  output logic [WE+WF+1:0] key_o,
  output logic             sign_o,
  output logic             is_zero_o,
  output logic             is_nan_o
);

  localparam int EXC_LO = exc_lsb(WE, WF);
  localparam int SGN    = sign_bit(WE, WF);

  logic [1:0]       w_exc;
  logic [WE+WF-1:0] w_payload;

  assign w_exc     = x_i[EXC_LO +: 2];
  assign w_payload = x_i[SGN-1:0];

  // Only normals carry a meaningful exp/frac; zero and inf payloads are
  // ignored so every zero ties and every infinity ties by exception code.
  assign key_o     = {w_exc, (w_exc == EXC_NORM) ? w_payload : '0};
  assign sign_o    = x_i[SGN];
  assign is_zero_o = (w_exc == EXC_ZERO);
  assign is_nan_o  = (w_exc == EXC_NAN);

endmodule
`default_nettype wire

// File: rtl/fp_compare_pipe.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fp_compare_pipe : two-stage valid/ready comparator and min/max select for FloPoCo floats
// Rev 1.0
// -----------------------------------------------------------------------------
module fp_compare_pipe
  import fp_flopoco_pkg::*;
#(
  parameter  int WE    = 11,
  parameter  int WF    = 10,
  parameter  int TAG_W = 8,
  localparam int W     = WE + WF + 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     inA,
  input  logic [W-1:0]     inB,
  input  logic [2:0]       op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res,
  output logic             unord,
  output logic [W-1:0]     sel,
  output logic [TAG_W-1:0] out_tag
);

  localparam int KW = WE + WF + 2;

  logic [KW-1:0]    w_key_a, w_key_b;
  logic             w_sign_a, w_sign_b, w_zero_a, w_zero_b, w_nan_a, w_nan_b;
  logic             w_adv1, w_adv2;

  logic             s1_valid_q, s1_gt_q, s1_eq_q, s1_sa_q, s1_sb_q;
  logic             s1_bz_q, s1_nana_q, s1_nanb_q;
  op_e              s1_op_q;
  logic [W-1:0]     s1_a_q, s1_b_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q, res_q, unord_q;
  logic [W-1:0]     sel_q;
  logic [TAG_W-1:0] tag_q;

  logic             w_eq, w_gt, w_lt, w_nan, w_pick_a;
  logic             res_d, unord_d;
  logic [W-1:0]     sel_d;

  fp_classify #(.WE(WE), .WF(WF)) u_cls_a (
    .x_i       (inA),
    .key_o     (w_key_a),
    .sign_o    (w_sign_a),
    .is_zero_o (w_zero_a),
    .is_nan_o  (w_nan_a)
  );

  fp_classify #(.WE(WE), .WF(WF)) u_cls_b (
    .x_i       (inB),
    .key_o     (w_key_b),
    .sign_o    (w_sign_b),
    .is_zero_o (w_zero_b),
    .is_nan_o  (w_nan_b)
  );

  assign w_adv2   = ~s2_valid_q | out_ready;
  assign w_adv1   = ~s1_valid_q | w_adv2;
  assign in_ready = w_adv1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_gt_q    <= 1'b0;
      s1_eq_q    <= 1'b0;
      s1_sa_q    <= 1'b0;
      s1_sb_q    <= 1'b0;
      s1_bz_q    <= 1'b0;
      s1_nana_q  <= 1'b0;
      s1_nanb_q  <= 1'b0;
      s1_op_q    <= OP_GE;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
    end else if (w_adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_gt_q   <= (w_key_a > w_key_b);
        s1_eq_q   <= (w_key_a == w_key_b);
        s1_sa_q   <= w_sign_a;
        s1_sb_q   <= w_sign_b;
        s1_bz_q   <= w_zero_a & w_zero_b;
        s1_nana_q <= w_nan_a;
        s1_nanb_q <= w_nan_b;
        s1_op_q   <= op_e'(op);
        s1_a_q    <= inA;
        s1_b_q    <= inB;
        s1_tag_q  <= in_tag;
      end
    end
  end

  always_comb begin
    w_eq     = s1_bz_q | (s1_eq_q & (s1_sa_q == s1_sb_q));
    w_gt     = 1'b0;
    w_nan    = s1_nana_q | s1_nanb_q;
    w_pick_a = 1'b1;
    res_d    = 1'b0;
    unord_d  = w_nan;

    // Differing signs: the positive side wins; negatives invert magnitude order
    if (s1_bz_q) begin
      w_gt = 1'b0;
    end else if (s1_sa_q != s1_sb_q) begin
      w_gt = ~s1_sa_q;
    end else if (!s1_sa_q) begin
      w_gt = s1_gt_q;
    end else begin
      w_gt = ~s1_gt_q & ~s1_eq_q;
    end
    w_lt = ~w_eq & ~w_gt;

    // NaN operands are skipped by min/max; two NaNs fall through to B
    case (s1_op_q)
      OP_MIN:  w_pick_a = s1_nana_q ? 1'b0 : (s1_nanb_q ? 1'b1 : ~w_gt);
      OP_MAX:  w_pick_a = s1_nana_q ? 1'b0 : (s1_nanb_q ? 1'b1 : ~w_lt);
      default: w_pick_a = 1'b1;
    endcase

    case (s1_op_q)
      OP_GE:   res_d = ~w_nan & (w_gt | w_eq);
      OP_GT:   res_d = ~w_nan & w_gt;
      OP_LE:   res_d = ~w_nan & (w_lt | w_eq);
      OP_LT:   res_d = ~w_nan & w_lt;
      OP_EQ:   res_d = ~w_nan & w_eq;
      OP_NE:   res_d = w_nan | ~w_eq;
      default: res_d = w_pick_a;
    endcase

    sel_d = w_pick_a ? s1_a_q : s1_b_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      res_q      <= 1'b0;
      unord_q    <= 1'b0;
      sel_q      <= '0;
      tag_q      <= '0;
    end else if (w_adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_q   <= res_d;
        unord_q <= unord_d;
        sel_q   <= sel_d;
        tag_q   <= s1_tag_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign res       = res_q;
  assign unord     = unord_q;
  assign sel       = sel_q;
  assign out_tag   = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_compare_pipe.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_fp_compare_pipe : scoreboard bench for fp_compare_pipe at 11/10 and 8/23 formats
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_fp_compare_pipe;
  import fp_flopoco_pkg::*;

  localparam int WE1 = 11, WF1 = 10, W1 = WE1 + WF1 + 3;
  localparam int WE2 = 8,  WF2 = 23, W2 = WE2 + WF2 + 3;

  typedef struct {
    logic        res;
    logic        unord;
    logic [63:0] sel;
    logic [7:0]  tag;
    int          cyc;
    bit          chk_lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, res, unord;
  logic [W1-1:0] inA = '0, inB = '0, sel;
  logic [2:0]    op = '0;
  logic [7:0]    in_tag = '0, out_tag;
  logic          in_valid2 = 1'b0, in_ready2, out_valid2, res2, unord2;
  logic [W2-1:0] inA2 = '0, inB2 = '0, sel2;
  logic [2:0]    op2 = '0;
  logic [7:0]    in_tag2 = '0, out_tag2;

  exp_t q1[$], q2[$];
  int   n_vec = 0, n_err = 0, cyc = 0;
  bit   lat_mode = 1'b0, rdy_rand = 1'b0;
  logic rdy_force = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_compare_pipe #(.WE(WE1), .WF(WF1), .TAG_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inA(inA), .inB(inB), .op(op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .unord(unord),
    .sel(sel), .out_tag(out_tag)
  );

  fp_compare_pipe #(.WE(WE2), .WF(WF2), .TAG_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .inA(inA2), .inB(inB2), .op(op2), .in_tag(in_tag2),
    .out_valid(out_valid2), .out_ready(out_ready), .res(res2), .unord(unord2),
    .sel(sel2), .out_tag(out_tag2)
  );

  // Real-valued meaning of an operand; exponent offset keeps 11-bit exps in double range
  function automatic real fp_val(input logic [63:0] x, input int we, input int wf);
    logic [63:0] ex, s, e, f;
    real m, bias;
    ex   = (x >> (we + wf + 1)) & 64'd3;
    s    = (x >> (we + wf)) & 64'd1;
    e    = (x >> wf) & ((64'd1 << we) - 64'd1);
    f    = x & ((64'd1 << wf) - 64'd1);
    bias = 2.0 ** (we - 1);
    if (ex == 64'd0)      m = 0.0;
    else if (ex == 64'd2) m = $bitstoreal(64'h7FF0000000000000);
    else m = (1.0 + real'(f) / (2.0 ** wf)) * (2.0 ** (real'(e) - bias));
    return (s != 64'd0) ? -m : m;
  endfunction

  function automatic exp_t ref_model(input logic [63:0] a, input logic [63:0] b,
                                     input logic [2:0] o, input logic [7:0] t,
                                     input int we, input int wf);
    exp_t e;
    real  va, vb;
    bit   na, nb, pick_a;
    na = ((a >> (we + wf + 1)) & 64'd3) == 64'd3;
    nb = ((b >> (we + wf + 1)) & 64'd3) == 64'd3;
    va = fp_val(a, we, wf);
    vb = fp_val(b, we, wf);
    e.unord = na || nb;
    e.tag = t; e.cyc = 0; e.chk_lat = 1'b0;
    pick_a = 1'b1;
    if (o == 3'd6) pick_a = na ? 1'b0 : (nb ? 1'b1 : (va <= vb));
    if (o == 3'd7) pick_a = na ? 1'b0 : (nb ? 1'b1 : (va >= vb));
    case (o)
      3'd0:    e.res = !e.unord && (va >= vb);
      3'd1:    e.res = !e.unord && (va > vb);
      3'd2:    e.res = !e.unord && (va <= vb);
      3'd3:    e.res = !e.unord && (va < vb);
      3'd4:    e.res = !e.unord && (va == vb);
      3'd5:    e.res = e.unord || (va != vb);
      default: e.res = pick_a;
    endcase
    e.sel = pick_a ? a : b;
    return e;
  endfunction

  // Biased operand generator: ties, sign flips, zeros with junk payload, inf, NaN
  function automatic logic [63:0] rand_opnd(input int we, input int wf, input logic [63:0] other);
    logic [63:0] x, fmask;
    int el;
    el    = we + wf + 1;
    fmask = (64'd1 << wf) - 64'd1;
    x = {$urandom, $urandom} & ((64'd1 << (we + wf + 3)) - 64'd1);
    x = (x & ~(64'd3 << el)) | (64'd1 << el);
    case ($urandom_range(0, 11))
      0:       x = other;
      1:       x = other ^ (64'd1 << (we + wf));
      2:       x = x & ~(64'd3 << el);
      3:       x = (x & ~(64'd3 << el)) | (64'd2 << el);
      4:       x = x | (64'd3 << el);
      5:       x = (x & fmask) | (other & ~fmask);
      6:       x = (x & ~fmask) | (other & fmask);
      default: ;
    endcase
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic send(input logic [W1-1:0] a, input logic [W1-1:0] b,
                      input logic [2:0] o, input logic [7:0] t);
    int k;
    k = 0;
    inA = a; inB = b; op = o; in_tag = t; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 200) begin @(negedge clk); k++; end
    if (!in_ready) chk("send_timeout1", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send2(input logic [W2-1:0] a, input logic [W2-1:0] b,
                       input logic [2:0] o, input logic [7:0] t);
    int k;
    k = 0;
    inA2 = a; inB2 = b; op2 = o; in_tag2 = t; in_valid2 = 1'b1;
    @(negedge clk);
    while (!in_ready2 && k < 200) begin @(negedge clk); k++; end
    if (!in_ready2) chk("send_timeout2", 64'(in_ready2), 64'd1);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
  endtask

  initial forever begin
    @(posedge clk); #2;
    out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  initial begin : mon1
    logic [W1+9:0] held;
    bit            hold;
    exp_t          e;
    hold = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q1.delete(); hold = 1'b0;
      end else begin
        if (hold) chk("stall_hold1", 64'({res, unord, sel, out_tag}), 64'(held));
        if (in_valid && in_ready) begin
          e = ref_model(64'(inA), 64'(inB), op, in_tag, WE1, WF1);
          e.cyc = cyc; e.chk_lat = lat_mode;
          q1.push_back(e);
        end
        if (out_valid && out_ready) begin
          if (q1.size() == 0) begin
            chk("unexpected_out1", 64'(out_valid), 64'd0);
          end else begin
            e = q1.pop_front();
            chk("res1", 64'(res), 64'(e.res));
            chk("unord1", 64'(unord), 64'(e.unord));
            chk("sel1", 64'(sel), e.sel);
            chk("tag1", 64'(out_tag), 64'(e.tag));
            if (e.chk_lat) chk("latency1", 64'(cyc - e.cyc), 64'd2);
          end
        end
        hold = out_valid && !out_ready;
        held = {res, unord, sel, out_tag};
      end
    end
  end

  initial begin : mon2
    logic [W2+9:0] held;
    bit            hold;
    exp_t          e;
    hold = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q2.delete(); hold = 1'b0;
      end else begin
        if (hold) chk("stall_hold2", 64'({res2, unord2, sel2, out_tag2}), 64'(held));
        if (in_valid2 && in_ready2) begin
          e = ref_model(64'(inA2), 64'(inB2), op2, in_tag2, WE2, WF2);
          q2.push_back(e);
        end
        if (out_valid2 && out_ready) begin
          if (q2.size() == 0) begin
            chk("unexpected_out2", 64'(out_valid2), 64'd0);
          end else begin
            e = q2.pop_front();
            chk("res2", 64'(res2), 64'(e.res));
            chk("unord2", 64'(unord2), 64'(e.unord));
            chk("sel2", 64'(sel2), e.sel);
            chk("tag2", 64'(out_tag2), 64'(e.tag));
          end
        end
        hold = out_valid2 && !out_ready;
        held = {res2, unord2, sel2, out_tag2};
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [63:0] a, b;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_unord", 64'(unord), 64'd0);
    chk("rst_sel", 64'(sel), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed ordered, signed-zero, negative, NaN and infinity cases
    lat_mode = 1'b1;
    send(24'h500000, 24'h4FFC00, OP_GE,  8'h10);
    send(24'h500000, 24'h4FFC00, OP_GT,  8'h11);
    send(24'h500000, 24'h4FFC00, OP_LT,  8'h12);
    send(24'h500000, 24'h4FFC00, OP_EQ,  8'h13);
    send(24'h000000, 24'h200000, OP_EQ,  8'h14);
    send(24'h6FFC00, 24'h4FFC00, OP_LT,  8'h15);
    send(24'h000000, 24'h200000, OP_MIN, 8'h16);
    send(24'h200000, 24'h000000, OP_MAX, 8'h17);
    send(24'hC00000, 24'h4FFC00, OP_GE,  8'h18);
    send(24'hC00000, 24'h4FFC00, OP_NE,  8'h19);
    send(24'hC00000, 24'h4FFC00, OP_MAX, 8'h1A);
    send(24'hC00123, 24'hC00456, OP_MIN, 8'h1B);
    send(24'h800000, 24'h500000, OP_GT,  8'h1C);
    send(24'hA00000, 24'h6FFC00, OP_LE,  8'h1D);
    repeat (4) @(posedge clk); #1;
    lat_mode = 1'b0;

    // Backpressure: two accepts fill the pipe, then in_ready must drop
    rdy_force = 1'b0;
    send(24'h500000, 24'h4FFC00, OP_GE,  8'h01);
    send(24'h4FFC00, 24'h500000, OP_GT,  8'h02);
    inA = 24'h6FFC00; inB = 24'h000000; op = OP_MIN; in_tag = 8'h03; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rdy_force = 1'b1;
    send(24'h6FFC00, 24'h000000, OP_MIN, 8'h03);
    send(24'h800000, 24'h800000, OP_EQ,  8'h04);
    repeat (4) @(posedge clk); #1;

    // Reset with both stages occupied
    rdy_force = 1'b0;
    send(24'h500000, 24'h4FFC00, OP_GT, 8'h05);
    send(24'h500000, 24'h4FFC00, OP_GE, 8'h06);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_res", 64'(res), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_res", 64'(res), 64'd0);
    @(posedge clk); #1;
    rdy_force = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("post_rst_idle", 64'(out_valid), 64'd0);
    lat_mode = 1'b1;
    send(24'h800000, 24'h500000, OP_GT, 8'h07);
    repeat (4) @(posedge clk); #1;
    lat_mode = 1'b0;

    // Random traffic with random backpressure, 11/10 format
    rdy_rand = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      a = rand_opnd(WE1, WF1, {$urandom, $urandom});
      b = rand_opnd(WE1, WF1, a);
      send(a[W1-1:0], b[W1-1:0], 3'($urandom_range(0, 7)), 8'(i));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    // Random traffic, 8/23 format
    for (int i = 0; i < 10000; i++) begin
      a = rand_opnd(WE2, WF2, {$urandom, $urandom});
      b = rand_opnd(WE2, WF2, a);
      send2(a[W2-1:0], b[W2-1:0], 3'($urandom_range(0, 7)), 8'(i));
      if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
    end

    rdy_rand = 1'b0;
    rdy_force = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("drain1", 64'(q1.size()), 64'd0);
    chk("drain2", 64'(q2.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
